// File: rtl/mem_port_arbiter_40_if.sv
// mem_port_arbiter_40_if
// Bundles the pipeline and DMA request/response signals together with the
// memory-side strobe/address/data signals of mem_port_arbiter_40.
// The arbiter connects through the slave modport; requesters and the RAM
// model connect through the master modport.
interface mem_port_arbiter_40_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // pipeline (MEM stage) requester
    logic          p_req_40;
    logic          p_we_40;
    logic [AW-1:0] p_addr_40;
    logic [DW-1:0] p_wdata_40;
    logic [DW-1:0] p_rdata_40;
    logic          p_done_40;
    logic          p_stall_40;

    // DMA / debug requester
    logic          d_req_40;
    logic          d_we_40;
    logic [AW-1:0] d_addr_40;
    logic [DW-1:0] d_wdata_40;
    logic [DW-1:0] d_rdata_40;
    logic          d_done_40;

    // single-port data memory
    logic          m_en_40;
    logic          m_we_40;
    logic [AW-1:0] m_addr_40;
    logic [DW-1:0] m_wdata_40;
    logic [DW-1:0] m_rdata_40;

    // status
    logic          busy_40;

    modport slave (
        input  p_req_40, p_we_40, p_addr_40, p_wdata_40,
        input  d_req_40, d_we_40, d_addr_40, d_wdata_40,
        input  m_rdata_40,
        output p_rdata_40, p_done_40, p_stall_40,
        output d_rdata_40, d_done_40,
        output m_en_40, m_we_40, m_addr_40, m_wdata_40,
        output busy_40
    );

    modport master (
        output p_req_40, p_we_40, p_addr_40, p_wdata_40,
        output d_req_40, d_we_40, d_addr_40, d_wdata_40,
        output m_rdata_40,
        input  p_rdata_40, p_done_40, p_stall_40,
        input  d_rdata_40, d_done_40,
        input  m_en_40, m_we_40, m_addr_40, m_wdata_40,
        input  busy_40
    );
endinterface

// File: rtl/mem_port_arbiter_40.sv
// mem_port_arbiter_40
// Shares the single-port data memory between the pipeline MEM stage and a
// DMA/debug requester. Each access is sequenced IDLE -> ISSUE -> WAIT -> DONE
// through a fixed-latency memory; the owner gets a one-cycle done pulse.
// Pipeline has fixed priority over DMA.
// Optional build macro: MEMARB_STARVE_GUARD_EN -- when defined, a starvation
// counter forces a DMA grant after STARVE_MAX consecutive pipeline grants
// taken while DMA was waiting.
// Read data is captured into the owner's rdata register on the clock edge
// that ends the DONE cycle (the memory drives valid data during DONE), so the
// registered rdata is visible from the cycle after the done pulse.
module mem_port_arbiter_40 #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk_40,
    input  logic                 rst_40,
    mem_port_arbiter_40_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    // elaboration-time guard on the legal parameter ranges
    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
        $error("mem_port_arbiter_40: MEM_LAT must be 1..7");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter_40: STARVE_MAX must be 1..15");
    end

    state_t        state;
    logic          owner_d;     // 1: current access belongs to DMA
    logic [2:0]    lat_cnt;
    logic          m_en_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic [DW-1:0] p_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          p_done_q;
    logic          d_done_q;
    logic          any_req;
    logic          grant_d;     // DMA wins the arbitration this IDLE cycle

    assign any_req = bus.p_req_40 | bus.d_req_40;

`ifdef MEMARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    // Pipeline priority, overridden once DMA has waited through STARVE_MAX pipeline grants.
    always_comb begin
        grant_d = bus.d_req_40 & (~bus.p_req_40 | (starve_cnt == STARVE_LIM));
    end

    // Count pipeline grants taken while DMA is waiting; clear on DMA grant or DMA idle.
    always_ff @(posedge clk_40 or negedge rst_40) begin
        if (!rst_40) begin
            starve_cnt <= 4'd0;
        end else if (!bus.d_req_40) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE && any_req) begin
            if (grant_d) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    // Strict pipeline priority: DMA only wins when the pipeline is not asking.
    always_comb begin
        grant_d = bus.d_req_40 & ~bus.p_req_40;
    end
`endif

    // Access sequencer: arbitrate and latch in IDLE, strobe once, count latency, return data.
    always_ff @(posedge clk_40 or negedge rst_40) begin
        if (!rst_40) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            lat_cnt   <= 3'd0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            p_rdata_q <= '0;
            d_rdata_q <= '0;
            p_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            m_en_q   <= 1'b0;
            p_done_q <= 1'b0;
            d_done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d   <= grant_d;
                        m_we_q    <= grant_d ? bus.d_we_40    : bus.p_we_40;
                        m_addr_q  <= grant_d ? bus.d_addr_40  : bus.p_addr_40;
                        m_wdata_q <= grant_d ? bus.d_wdata_40 : bus.p_wdata_40;
                        m_en_q    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    if (MEM_LAT == 1) begin
                        state    <= DONE;
                        p_done_q <= ~owner_d;
                        d_done_q <= owner_d;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        state    <= DONE;
                        p_done_q <= ~owner_d;
                        d_done_q <= owner_d;
                    end
                end
                DONE: begin
                    if (!m_we_q) begin
                        if (owner_d) begin
                            d_rdata_q <= bus.m_rdata_40;
                        end else begin
                            p_rdata_q <= bus.m_rdata_40;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_en_40    = m_en_q;
    assign bus.m_we_40    = m_we_q;
    assign bus.m_addr_40  = m_addr_q;
    assign bus.m_wdata_40 = m_wdata_q;
    assign bus.p_rdata_40 = p_rdata_q;
    assign bus.d_rdata_40 = d_rdata_q;
    assign bus.p_done_40  = p_done_q;
    assign bus.d_done_40  = d_done_q;
    assign bus.busy_40    = (state != IDLE);
    // Stall is held low while reset is asserted so every output reads 0 in reset.
    assign bus.p_stall_40 = rst_40 & bus.p_req_40 & ~p_done_q;

endmodule

// File: tb/tb_mem_port_arbiter_40.sv
// tb_mem_port_arbiter_40
// Scoreboard bench for mem_port_arbiter_40 with a MEM_LAT-cycle RAM model.
// Expected accesses are queued per requester when driven and retired on the
// matching done pulse. Build with MEMARB_STARVE_GUARD_EN to cover the guard.
`timescale 1ns/1ps
module tb_mem_port_arbiter_40;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk_40 = 1'b0;
    logic rst_40;
    logic preload;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_40 = ~clk_40;
    always @(posedge clk_40) cyc <= cyc + 1;

    mem_port_arbiter_40_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter_40 #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_40 (clk_40),
        .rst_40 (rst_40),
        .bus    (bus)
    );

    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
    endfunction

    // RAM model: read data appears MEM_LAT cycles after the strobe, for one cycle only
    logic [DW-1:0] ram     [0:255];
    logic [DW-1:0] rd_pipe [0:MEM_LAT-1];
    logic [DW-1:0] ref_mem [0:255];

    always @(posedge clk_40) begin
        if (preload) begin
            for (int j = 0; j < 256; j++) ram[j] <= init_val(8'(j));
        end else if (bus.m_en_40 && bus.m_we_40) begin
            ram[bus.m_addr_40[7:0]] <= bus.m_wdata_40;
        end
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (bus.m_en_40 && !bus.m_we_40) ? ram[bus.m_addr_40[7:0]] : 32'hBAD0BAD0;
    end
    assign bus.m_rdata_40 = rd_pipe[MEM_LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard
    exp_t          p_q[$];
    exp_t          d_q[$];
    int            en_cyc;
    logic          en_we;
    logic [AW-1:0] en_addr;
    logic [DW-1:0] en_wdata;
    logic          p_pend = 1'b0;
    logic          d_pend = 1'b0;
    logic [DW-1:0] p_want;
    logic [DW-1:0] d_want;

    task automatic retire(input bit is_d);
        exp_t e;
        if (is_d) begin
            if (d_q.size() == 0) begin check("d_unexpected_done", d_q.size(), 1); return; end
            e = d_q.pop_front();
        end else begin
            if (p_q.size() == 0) begin check("p_unexpected_done", p_q.size(), 1); return; end
            e = p_q.pop_front();
        end
        check("strobe_to_done", cyc - en_cyc, MEM_LAT);
        check("m_we", en_we, e.we);
        check("m_addr", en_addr, e.addr);
        if (e.we) check("m_wdata", en_wdata, e.data);
        if (e.due >= 0) check(is_d ? "d_done_cycle" : "p_done_cycle", cyc, e.due);
        if (is_d) begin
            d_pend = 1'b1;
            d_want = e.we ? bus.d_rdata_40 : e.data;
        end else begin
            p_pend = 1'b1;
            p_want = e.we ? bus.p_rdata_40 : e.data;
        end
    endtask

    // monitor on the falling edge
    always @(negedge clk_40) begin
        if (rst_40) begin
            check("p_stall", bus.p_stall_40, bus.p_req_40 & ~bus.p_done_40);
            if (p_pend) begin check("p_rdata", bus.p_rdata_40, p_want); p_pend = 1'b0; end
            if (d_pend) begin check("d_rdata", bus.d_rdata_40, d_want); d_pend = 1'b0; end
            if (bus.m_en_40) begin
                en_cyc   = cyc;
                en_we    = bus.m_we_40;
                en_addr  = bus.m_addr_40;
                en_wdata = bus.m_wdata_40;
            end
            if (bus.p_done_40) retire(1'b0);
            if (bus.d_done_40) retire(1'b1);
        end else begin
            p_pend = 1'b0;
            d_pend = 1'b0;
        end
    end

    function automatic exp_t mk_exp(input logic we, input logic [AW-1:0] addr,
                                    input logic [DW-1:0] data, input int due);
        exp_t e;
        e.we   = we;
        e.addr = addr;
        e.due  = due;
        if (we) begin
            e.data = data;
            ref_mem[addr[7:0]] = data;
        end else begin
            e.data = ref_mem[addr[7:0]];
        end
        return e;
    endfunction

    // one access from an idle DUT; returns in the IDLE cycle after done
    task automatic access(input bit is_d, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
        bit seen = 1'b0;
        if (is_d) begin
            d_q.push_back(mk_exp(we, addr, data, cyc + 1 + MEM_LAT));
            bus.d_we_40 = we; bus.d_addr_40 = addr; bus.d_wdata_40 = data; bus.d_req_40 = 1'b1;
        end else begin
            p_q.push_back(mk_exp(we, addr, data, cyc + 1 + MEM_LAT));
            bus.p_we_40 = we; bus.p_addr_40 = addr; bus.p_wdata_40 = data; bus.p_req_40 = 1'b1;
        end
        #1;
        check("busy_at_req", bus.busy_40, 1'b0);
        if (!is_d) check("p_stall_at_req", bus.p_stall_40, 1'b1);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk_40); #1;
            if (is_d ? bus.d_done_40 : bus.p_done_40) begin
                seen = 1'b1;
                if (!is_d) check("p_stall_at_done", bus.p_stall_40, 1'b0);
                if (is_d) bus.d_req_40 = 1'b0; else bus.p_req_40 = 1'b0;
            end
        end
        check(is_d ? "d_done_seen" : "p_done_seen", seen, 1'b1);
        @(posedge clk_40); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit p_seen, d_seen;
        int pc, d_at, due0;

        rst_40 = 1'b0; preload = 1'b1;
        bus.p_req_40 = 1'b0; bus.p_we_40 = 1'b0; bus.p_addr_40 = '0; bus.p_wdata_40 = '0;
        bus.d_req_40 = 1'b0; bus.d_we_40 = 1'b0; bus.d_addr_40 = '0; bus.d_wdata_40 = '0;
        for (int j = 0; j < 256; j++) ref_mem[j] = init_val(8'(j));
        repeat (3) @(posedge clk_40);
        #1;
        check("rst_m_en",    bus.m_en_40,    1'b0);
        check("rst_m_we",    bus.m_we_40,    1'b0);
        check("rst_m_addr",  bus.m_addr_40,  32'h0);
        check("rst_m_wdata", bus.m_wdata_40, 32'h0);
        check("rst_p_rdata", bus.p_rdata_40, 32'h0);
        check("rst_d_rdata", bus.d_rdata_40, 32'h0);
        check("rst_p_done",  bus.p_done_40,  1'b0);
        check("rst_d_done",  bus.d_done_40,  1'b0);
        check("rst_busy",    bus.busy_40,    1'b0);
        @(posedge clk_40); #1;
        rst_40 = 1'b1; preload = 1'b0;
        @(posedge clk_40); #1;

        // pipeline load, store, load-back
        access(1'b0, 1'b0, 32'h10, 32'h0);
        access(1'b0, 1'b1, 32'h20, 32'h12345678);
        access(1'b0, 1'b0, 32'h20, 32'h0);
        // DMA store, load-back, load
        access(1'b1, 1'b1, 32'h30, 32'hA5A55A5A);
        access(1'b1, 1'b0, 32'h30, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0);

        // simultaneous requests: pipeline first, DMA one access period later
        due0 = cyc + 1 + MEM_LAT;
        p_q.push_back(mk_exp(1'b0, 32'h20, 32'h0, due0));
        d_q.push_back(mk_exp(1'b0, 32'h30, 32'h0, due0 + MEM_LAT + 2));
        bus.p_we_40 = 1'b0; bus.p_addr_40 = 32'h20; bus.p_req_40 = 1'b1;
        bus.d_we_40 = 1'b0; bus.d_addr_40 = 32'h30; bus.d_req_40 = 1'b1;
        p_seen = 1'b0; d_seen = 1'b0;
        for (int k = 0; k < 40 && !(p_seen && d_seen); k++) begin
            @(posedge clk_40); #1;
            if (bus.p_done_40) begin p_seen = 1'b1; bus.p_req_40 = 1'b0; end
            if (bus.d_done_40) begin d_seen = 1'b1; bus.d_req_40 = 1'b0; end
        end
        check("both_p_done_seen", p_seen, 1'b1);
        check("both_d_done_seen", d_seen, 1'b1);
        @(posedge clk_40); #1;

`ifdef MEMARB_STARVE_GUARD_EN
        // guard: p,p,p,d,p with both requests held
        for (int k = 0; k < 4; k++) p_q.push_back(mk_exp(1'b0, 32'h50, 32'h0, -1));
        d_q.push_back(mk_exp(1'b0, 32'h60, 32'h0, -1));
        bus.p_addr_40 = 32'h50; bus.p_req_40 = 1'b1;
        bus.d_addr_40 = 32'h60; bus.d_req_40 = 1'b1;
        pc = 0; d_at = -1;
        for (int k = 0; k < 100 && (bus.p_req_40 || bus.d_req_40); k++) begin
            @(posedge clk_40); #1;
            if (bus.d_done_40) begin d_at = pc; bus.d_req_40 = 1'b0; end
            if (bus.p_done_40) begin pc++; if (pc == 4) bus.p_req_40 = 1'b0; end
        end
        check("starve_p_before_d", d_at, STARVE_MAX);
        check("starve_p_total", pc, 4);
`else
        // no guard: DMA waits through 100 pipeline accesses
        for (int k = 0; k < 100; k++) p_q.push_back(mk_exp(1'b0, 32'h50, 32'h0, -1));
        d_q.push_back(mk_exp(1'b0, 32'h60, 32'h0, -1));
        bus.p_addr_40 = 32'h50; bus.p_req_40 = 1'b1;
        bus.d_addr_40 = 32'h60; bus.d_req_40 = 1'b1;
        pc = 0; d_at = -1;
        for (int k = 0; k < 100 * (MEM_LAT + 2) + 50 && (bus.p_req_40 || bus.d_req_40); k++) begin
            @(posedge clk_40); #1;
            if (bus.d_done_40) begin d_at = pc; bus.d_req_40 = 1'b0; end
            if (bus.p_done_40) begin pc++; if (pc == 100) bus.p_req_40 = 1'b0; end
        end
        check("nostarve_p_before_d", d_at, 100);
        check("nostarve_p_total", pc, 100);
`endif
        @(posedge clk_40); #1;

        // reset during WAIT, then restart with the request still held
        bus.p_we_40 = 1'b0; bus.p_addr_40 = 32'h10; bus.p_req_40 = 1'b1;
        @(posedge clk_40); #1;
        check("pre_rst_m_en", bus.m_en_40, 1'b1);
        @(posedge clk_40); #1;
        check("pre_rst_busy", bus.busy_40, 1'b1);
        rst_40 = 1'b0;
        #1;
        check("midrst_m_en",    bus.m_en_40,    1'b0);
        check("midrst_p_done",  bus.p_done_40,  1'b0);
        check("midrst_busy",    bus.busy_40,    1'b0);
        check("midrst_p_stall", bus.p_stall_40, 1'b0);
        check("midrst_p_rdata", bus.p_rdata_40, 32'h0);
        check("midrst_m_addr",  bus.m_addr_40,  32'h0);
        p_q.delete();
        repeat (2) @(posedge clk_40);
        #1;
        p_q.push_back(mk_exp(1'b0, 32'h10, 32'h0, cyc + 1 + MEM_LAT));
        rst_40 = 1'b1;
        p_seen = 1'b0;
        for (int k = 0; k < 20 && !p_seen; k++) begin
            @(posedge clk_40); #1;
            if (bus.p_done_40) begin p_seen = 1'b1; bus.p_req_40 = 1'b0; end
        end
        check("post_rst_done_seen", p_seen, 1'b1);
        repeat (2) @(posedge clk_40);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
